// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding, oversampling
// default and line-control word-length decode helpers.
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;

  // WLS 00..11 selects 5..8 data bits; the mask keeps only the used bits.
  function automatic logic [7:0] wordMask(input logic [1:0] wls);
    logic [2:0] dropBits;
    dropBits = 3'd3 - {1'b0, wls};
    return 8'hFF >> dropBits;
  endfunction

  function automatic logic [2:0] lastDataBit(input logic [1:0] wls);
    return {1'b1, wls};
  endfunction

endpackage

// File: rtl/slib_counter.sv
// Free-running enable counter with synchronous clear; OVERFLOW flags the
// enabled cycle in which the count wraps from all-ones back to zero.
module slib_counter #(
  parameter int WIDTH = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLEAR,
  input  logic ENABLE,
  output logic OVERFLOW
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (CLEAR) begin
      count <= '0;
    end else if (ENABLE) begin
      count <= count + WIDTH'(1);
    end
  end

  assign OVERFLOW = ENABLE & ~CLEAR & (&count);

endmodule

// File: rtl/uart_transmitter.sv
// UART character serialiser: start bit, 5-8 data bits LSB first, optional
// parity, 1/1.5/2 stop bits, with break control overriding the line.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TXCLK,
  input  logic       TXCLEAR,
  input  logic       TXSTART,
  input  logic [7:0] DIN,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  output logic       SOUT,
  output logic       TXBUSY,
  output logic       TXFINISHED
);

  localparam int BAUD_W = $clog2(OVERSAMPLE);
  localparam int STOP_W = $clog2(2 * OVERSAMPLE);

  tx_state_t         state;
  logic [7:0]        shiftReg;
  logic [2:0]        bitCount;
  logic [2:0]        lastBit;
  logic [STOP_W-1:0] stopCount;
  logic [STOP_W-1:0] stopLast;
  logic              penLatched;
  logic              parityBit;
  logic              sout;
  logic              txFinished;
  logic              baudClear;
  logic              bitTick;
  logic [7:0]        maskedDin;
  logic              parityNext;

  assign baudClear  = (state == IDLE) | TXCLEAR;
  assign maskedDin  = DIN & wordMask(WLS);
  assign parityNext = SP ? ~EPS : (^maskedDin ^ ~EPS);

  slib_counter #(.WIDTH(BAUD_W)) baudCounter (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CLEAR    (baudClear),
    .ENABLE   (TXCLK),
    .OVERFLOW (bitTick)
  );

  // Line value is computed for the state being entered so SOUT stays registered;
  // the stop period counts raw TXCLK pulses so 1.5 stop bits need no extra state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      sout       <= 1'b1;
      txFinished <= 1'b0;
      shiftReg   <= '0;
      bitCount   <= '0;
      lastBit    <= '0;
      stopCount  <= '0;
      stopLast   <= '0;
      penLatched <= 1'b0;
      parityBit  <= 1'b0;
    end else if (TXCLEAR) begin
      state      <= IDLE;
      sout       <= ~BC;
      txFinished <= 1'b0;
      bitCount   <= '0;
      stopCount  <= '0;
    end else begin
      txFinished <= 1'b0;
      case (state)
        IDLE: begin
          sout <= ~BC;
          if (TXSTART && !txFinished) begin
            state      <= START;
            shiftReg   <= maskedDin;
            lastBit    <= lastDataBit(WLS);
            penLatched <= PEN;
            parityBit  <= parityNext;
            bitCount   <= '0;
            stopCount  <= '0;
            sout       <= 1'b0;
            if (!STB) begin
              stopLast <= STOP_W'(OVERSAMPLE - 1);
            end else if (WLS == 2'b00) begin
              stopLast <= STOP_W'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
            end else begin
              stopLast <= STOP_W'(2 * OVERSAMPLE - 1);
            end
          end
        end
        START: begin
          sout <= 1'b0;
          if (bitTick) begin
            state    <= DATA;
            bitCount <= '0;
            sout     <= shiftReg[0] & ~BC;
          end
        end
        DATA: begin
          sout <= shiftReg[0] & ~BC;
          if (bitTick) begin
            if (bitCount == lastBit) begin
              state     <= penLatched ? PAR : STOP;
              stopCount <= '0;
              sout      <= (penLatched ? parityBit : 1'b1) & ~BC;
            end else begin
              shiftReg <= shiftReg >> 1;
              bitCount <= bitCount + 3'd1;
              sout     <= shiftReg[1] & ~BC;
            end
          end
        end
        PAR: begin
          sout <= parityBit & ~BC;
          if (bitTick) begin
            state     <= STOP;
            stopCount <= '0;
            sout      <= ~BC;
          end
        end
        STOP: begin
          sout <= ~BC;
          if (TXCLK) begin
            if (stopCount == stopLast) begin
              state      <= IDLE;
              txFinished <= 1'b1;
            end else begin
              stopCount <= stopCount + STOP_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          sout  <= ~BC;
        end
      endcase
    end
  end

  assign SOUT       = sout;
  assign TXBUSY     = (state != IDLE);
  assign TXFINISHED = txFinished;

endmodule
